// File: rtl/mem_arbiter.sv
// Two-port memory arbiter: buffers one request per requester and runs one
// transaction at a time on the shared downstream word-addressed port.
module mem_arbiter #(
  parameter int AW = 30,
  parameter int RR = 1
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          a_re,
  input  logic [3:0]    a_we,
  input  logic [AW-1:0] a_addr,
  input  logic [31:0]   a_wdata,
  output logic [31:0]   a_rdata,
  output logic          a_mem_ready,
  input  logic          b_re,
  input  logic [3:0]    b_we,
  input  logic [AW-1:0] b_addr,
  input  logic [31:0]   b_wdata,
  output logic [31:0]   b_rdata,
  output logic          b_mem_ready,
  output logic          re,
  output logic [3:0]    we,
  output logic [AW-1:0] addr,
  output logic [31:0]   wdata,
  input  logic [31:0]   rdata,
  input  logic          mem_ready
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ISSUE = 2'd1;
  localparam logic [1:0] S_WAIT  = 2'd2;
  localparam logic [1:0] S_RESP  = 2'd3;

  logic [1:0]    r_state;
  logic          r_pendA, r_pendB;
  logic          r_aRe, r_bRe;
  logic [3:0]    r_aWe, r_bWe;
  logic [AW-1:0] r_aAddr, r_bAddr;
  logic [31:0]   r_aWdata, r_bWdata;
  logic          r_opRe;
  logic [3:0]    r_opWe;
  logic [AW-1:0] r_addr;
  logic [31:0]   r_wdata;
  logic          r_sel;
  logic          r_lastSel;
  logic [31:0]   r_rdata;

  logic w_aReq, w_bReq, w_clrA, w_clrB, w_pickB;

  assign w_aReq = a_re | (|a_we);
  assign w_bReq = b_re | (|b_we);
  assign w_clrA = (r_state == S_RESP) && !r_sel;
  assign w_clrB = (r_state == S_RESP) && r_sel;
  // sel/lastSel encoding: 0 = port A, 1 = port B
  assign w_pickB = r_pendB && (!r_pendA || ((RR != 0) && !r_lastSel));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_pendA  <= 1'b0;
      r_pendB  <= 1'b0;
      r_aRe    <= 1'b0;
      r_bRe    <= 1'b0;
      r_aWe    <= 4'b0;
      r_bWe    <= 4'b0;
      r_aAddr  <= '0;
      r_bAddr  <= '0;
      r_aWdata <= 32'b0;
      r_bWdata <= 32'b0;
    end else begin
      if (w_aReq) begin
        r_aRe    <= a_re;
        r_aWe    <= a_we;
        r_aAddr  <= a_addr;
        r_aWdata <= a_wdata;
      end
      if (w_bReq) begin
        r_bRe    <= b_re;
        r_bWe    <= b_we;
        r_bAddr  <= b_addr;
        r_bWdata <= b_wdata;
      end
      // The RESP clear takes precedence over a same-cycle strobe
      if (w_clrA)      r_pendA <= 1'b0;
      else if (w_aReq) r_pendA <= 1'b1;
      if (w_clrB)      r_pendB <= 1'b0;
      else if (w_bReq) r_pendB <= 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state   <= S_IDLE;
      r_opRe    <= 1'b0;
      r_opWe    <= 4'b0;
      r_addr    <= '0;
      r_wdata   <= 32'b0;
      r_sel     <= 1'b0;
      r_lastSel <= 1'b1;
      r_rdata   <= 32'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (r_pendA || r_pendB) begin
            r_sel   <= w_pickB;
            r_opRe  <= w_pickB ? r_bRe    : r_aRe;
            r_opWe  <= w_pickB ? r_bWe    : r_aWe;
            r_addr  <= w_pickB ? r_bAddr  : r_aAddr;
            r_wdata <= w_pickB ? r_bWdata : r_aWdata;
            r_state <= S_ISSUE;
          end
        end
        S_ISSUE, S_WAIT: begin
          if (mem_ready) begin
            r_rdata <= rdata;
            r_state <= S_RESP;
          end else begin
            r_state <= S_WAIT;
          end
        end
        S_RESP: begin
          r_lastSel <= r_sel;
          r_state   <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign re          = (r_state == S_ISSUE) & r_opRe;
  assign we          = (r_state == S_ISSUE) ? r_opWe : 4'b0;
  assign addr        = r_addr;
  assign wdata       = r_wdata;
  assign a_mem_ready = (r_state == S_RESP) & ~r_sel;
  assign b_mem_ready = (r_state == S_RESP) & r_sel;
  assign a_rdata     = r_rdata;
  assign b_rdata     = r_rdata;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: a round-robin and a fixed-priority instance
// share the requester inputs and the memory response.
module tb_mem_arbiter;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        aRe = 1'b0, bRe = 1'b0;
  logic [3:0]  aWe = 4'b0, bWe = 4'b0;
  logic [29:0] aAddr = '0, bAddr = '0;
  logic [31:0] aWdata = '0, bWdata = '0;
  logic [31:0] rdata = '0;
  logic        memReady = 1'b0;

  logic [31:0] aRdata1, bRdata1, aRdata0, bRdata0;
  logic        aMemReady1, bMemReady1, aMemReady0, bMemReady0;
  logic        re1, re0;
  logic [3:0]  we1, we0;
  logic [29:0] addr1, addr0;
  logic [31:0] wdata1, wdata0;

  int checks = 0;
  int errors = 0;
  logic aOut, bOut;

  always #5 clk = ~clk;

  mem_arbiter #(.AW(30), .RR(1)) dutRr (
    .clk(clk), .reset(reset),
    .a_re(aRe), .a_we(aWe), .a_addr(aAddr), .a_wdata(aWdata),
    .a_rdata(aRdata1), .a_mem_ready(aMemReady1),
    .b_re(bRe), .b_we(bWe), .b_addr(bAddr), .b_wdata(bWdata),
    .b_rdata(bRdata1), .b_mem_ready(bMemReady1),
    .re(re1), .we(we1), .addr(addr1), .wdata(wdata1),
    .rdata(rdata), .mem_ready(memReady)
  );

  mem_arbiter #(.AW(30), .RR(0)) dutFixed (
    .clk(clk), .reset(reset),
    .a_re(aRe), .a_we(aWe), .a_addr(aAddr), .a_wdata(aWdata),
    .a_rdata(aRdata0), .a_mem_ready(aMemReady0),
    .b_re(bRe), .b_we(bWe), .b_addr(bAddr), .b_wdata(bWdata),
    .b_rdata(bRdata0), .b_mem_ready(bMemReady0),
    .re(re0), .we(we0), .addr(addr0), .wdata(wdata0),
    .rdata(rdata), .mem_ready(memReady)
  );

  // Requester protocol monitor: no new strobe while a port is outstanding
  always @(posedge clk or posedge reset) begin
    if (reset) begin
      aOut <= 1'b0;
      bOut <= 1'b0;
    end else begin
      assert (!((aRe || (|aWe)) && aOut)) else $error("[TB] port A strobe while outstanding");
      assert (!((bRe || (|bWe)) && bOut)) else $error("[TB] port B strobe while outstanding");
      if (aRe || (|aWe)) aOut <= 1'b1;
      else if (aMemReady1) aOut <= 1'b0;
      if (bRe || (|bWe)) bOut <= 1'b1;
      else if (bMemReady1) bOut <= 1'b0;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    tick();
    checks++;
    if (re1 !== 1'b0 || we1 !== 4'b0) begin
      errors++;
      $display("[TB] FAIL reset_strobes: got re=%0b we=%b expected re=0 we=0000", re1, we1);
    end
    checks++;
    if (addr1 !== 30'h0 || wdata1 !== 32'h0) begin
      errors++;
      $display("[TB] FAIL reset_bus: got addr=%h wdata=%h expected 0/0", addr1, wdata1);
    end
    checks++;
    if (aMemReady1 !== 1'b0 || bMemReady1 !== 1'b0 || aRdata1 !== 32'h0) begin
      errors++;
      $display("[TB] FAIL reset_resp: got aRdy=%0b bRdy=%0b aRdata=%h expected 0/0/0",
               aMemReady1, bMemReady1, aRdata1);
    end
  endtask

  task automatic test_single_read();
    aRe = 1'b1; aAddr = 30'h10;
    tick();
    aRe = 1'b0; aAddr = 30'h0;
    checks++;
    if (re1 !== 1'b0) begin
      errors++;
      $display("[TB] FAIL read_early_re: got %0b expected 0", re1);
    end
    tick();
    checks++;
    if (re1 !== 1'b1 || addr1 !== 30'h10 || we1 !== 4'b0) begin
      errors++;
      $display("[TB] FAIL read_issue: got re=%0b addr=%h we=%b expected 1/10/0000", re1, addr1, we1);
    end
    tick();
    checks++;
    if (re1 !== 1'b0 || aMemReady1 !== 1'b0) begin
      errors++;
      $display("[TB] FAIL read_wait: got re=%0b aRdy=%0b expected 0/0", re1, aMemReady1);
    end
    memReady = 1'b1; rdata = 32'hDEADBEEF;
    tick();
    memReady = 1'b0; rdata = 32'h0;
    checks++;
    if (aMemReady1 !== 1'b1 || aRdata1 !== 32'hDEADBEEF || bMemReady1 !== 1'b0) begin
      errors++;
      $display("[TB] FAIL read_resp: got aRdy=%0b aRdata=%h bRdy=%0b expected 1/deadbeef/0",
               aMemReady1, aRdata1, bMemReady1);
    end
    tick();
    checks++;
    if (aMemReady1 !== 1'b0) begin
      errors++;
      $display("[TB] FAIL read_resp_pulse: got %0b expected 0", aMemReady1);
    end
  endtask

  task automatic test_byte_write();
    bWe = 4'b0100; bAddr = 30'h3; bWdata = 32'h00AB0000;
    tick();
    bWe = 4'b0; bAddr = 30'h0; bWdata = 32'h0;
    tick();
    checks++;
    if (we1 !== 4'b0100 || re1 !== 1'b0 || addr1 !== 30'h3 || wdata1 !== 32'h00AB0000) begin
      errors++;
      $display("[TB] FAIL write_issue: got we=%b re=%0b addr=%h wdata=%h expected 0100/0/3/00ab0000",
               we1, re1, addr1, wdata1);
    end
    tick();
    checks++;
    if (we1 !== 4'b0) begin
      errors++;
      $display("[TB] FAIL write_one_cycle: got we=%b expected 0000", we1);
    end
    memReady = 1'b1;
    tick();
    memReady = 1'b0;
    checks++;
    if (bMemReady1 !== 1'b1 || aMemReady1 !== 1'b0) begin
      errors++;
      $display("[TB] FAIL write_resp: got bRdy=%0b aRdy=%0b expected 1/0", bMemReady1, aMemReady1);
    end
    tick();
  endtask

  // Both ports strobe reads together; bFirst is the expected round-robin order
  task automatic collide(input logic bFirst);
    logic [29:0] firstAddr, secondAddr;
    firstAddr  = bFirst ? 30'h30 : 30'h20;
    secondAddr = bFirst ? 30'h20 : 30'h30;
    aRe = 1'b1; aAddr = 30'h20;
    bRe = 1'b1; bAddr = 30'h30;
    tick();
    aRe = 1'b0; bRe = 1'b0; aAddr = 30'h0; bAddr = 30'h0;
    tick();
    checks++;
    if (addr1 !== firstAddr || re1 !== 1'b1 || addr0 !== 30'h20) begin
      errors++;
      $display("[TB] FAIL collide_first_issue: got rr=%h re=%0b fixed=%h expected %h/1/20",
               addr1, re1, addr0, firstAddr);
    end
    memReady = 1'b1; rdata = 32'h11111111;
    tick();
    memReady = 1'b0; rdata = 32'h0;
    checks++;
    if (aMemReady1 !== ~bFirst || bMemReady1 !== bFirst || aMemReady0 !== 1'b1 || aRdata1 !== 32'h11111111) begin
      errors++;
      $display("[TB] FAIL collide_first_resp: got rrA=%0b rrB=%0b fixA=%0b data=%h expected %0b/%0b/1/11111111",
               aMemReady1, bMemReady1, aMemReady0, aRdata1, ~bFirst, bFirst);
    end
    tick();
    tick();
    checks++;
    if (addr1 !== secondAddr || re1 !== 1'b1 || addr0 !== 30'h30) begin
      errors++;
      $display("[TB] FAIL collide_second_issue: got rr=%h re=%0b fixed=%h expected %h/1/30",
               addr1, re1, addr0, secondAddr);
    end
    memReady = 1'b1; rdata = 32'h22222222;
    tick();
    memReady = 1'b0; rdata = 32'h0;
    checks++;
    if (aMemReady1 !== bFirst || bMemReady1 !== ~bFirst || bMemReady0 !== 1'b1 || bRdata0 !== 32'h22222222) begin
      errors++;
      $display("[TB] FAIL collide_second_resp: got rrA=%0b rrB=%0b fixB=%0b data=%h expected %0b/%0b/1/22222222",
               aMemReady1, bMemReady1, bMemReady0, bRdata0, bFirst, ~bFirst);
    end
    tick();
  endtask

  task automatic test_collision_first();
    collide(1'b0);
  endtask

  task automatic test_zero_wait();
    aRe = 1'b1; aAddr = 30'h5;
    tick();
    aRe = 1'b0; aAddr = 30'h0;
    tick();
    checks++;
    if (re1 !== 1'b1 || addr1 !== 30'h5) begin
      errors++;
      $display("[TB] FAIL zero_wait_issue: got re=%0b addr=%h expected 1/5", re1, addr1);
    end
    memReady = 1'b1; rdata = 32'h0BADCAFE;
    tick();
    memReady = 1'b0; rdata = 32'h0;
    checks++;
    if (aMemReady1 !== 1'b1 || aRdata1 !== 32'h0BADCAFE || re1 !== 1'b0) begin
      errors++;
      $display("[TB] FAIL zero_wait_resp: got aRdy=%0b aRdata=%h re=%0b expected 1/0badcafe/0",
               aMemReady1, aRdata1, re1);
    end
    tick();
  endtask

  task automatic test_collision_second();
    collide(1'b1);
  endtask

  task automatic test_wait_states();
    aRe = 1'b1; aAddr = 30'h40;
    tick();
    aRe = 1'b0; aAddr = 30'h0;
    tick();
    checks++;
    if (re1 !== 1'b1 || addr1 !== 30'h40) begin
      errors++;
      $display("[TB] FAIL wait_issue: got re=%0b addr=%h expected 1/40", re1, addr1);
    end
    tick();
    bWe = 4'hF; bAddr = 30'h50; bWdata = 32'hCAFEF00D;
    tick();
    bWe = 4'h0; bAddr = 30'h0; bWdata = 32'h0;
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (addr1 !== 30'h40 || re1 !== 1'b0 || we1 !== 4'b0) begin
        errors++;
        $display("[TB] FAIL wait_hold_%0d: got addr=%h re=%0b we=%b expected 40/0/0000", i, addr1, re1, we1);
      end
      if (i < 3) tick();
    end
    memReady = 1'b1; rdata = 32'h12345678;
    tick();
    memReady = 1'b0; rdata = 32'h0;
    checks++;
    if (aMemReady1 !== 1'b1 || aRdata1 !== 32'h12345678 || bMemReady1 !== 1'b0) begin
      errors++;
      $display("[TB] FAIL wait_resp_a: got aRdy=%0b aRdata=%h bRdy=%0b expected 1/12345678/0",
               aMemReady1, aRdata1, bMemReady1);
    end
    tick();
    tick();
    checks++;
    if (we1 !== 4'hF || addr1 !== 30'h50 || wdata1 !== 32'hCAFEF00D) begin
      errors++;
      $display("[TB] FAIL wait_issue_b: got we=%b addr=%h wdata=%h expected 1111/50/cafef00d",
               we1, addr1, wdata1);
    end
    memReady = 1'b1;
    tick();
    memReady = 1'b0;
    checks++;
    if (bMemReady1 !== 1'b1 || aMemReady1 !== 1'b0) begin
      errors++;
      $display("[TB] FAIL wait_resp_b: got bRdy=%0b aRdy=%0b expected 1/0", bMemReady1, aMemReady1);
    end
    tick();
  endtask

  task automatic test_reset_mid_wait();
    aRe = 1'b1; aAddr = 30'h60;
    tick();
    aRe = 1'b0; aAddr = 30'h0;
    tick();
    tick();
    reset = 1'b1;
    #1;
    checks++;
    if (re1 !== 1'b0 || we1 !== 4'b0 || addr1 !== 30'h0 || wdata1 !== 32'h0) begin
      errors++;
      $display("[TB] FAIL async_reset: got re=%0b we=%b addr=%h wdata=%h expected all 0",
               re1, we1, addr1, wdata1);
    end
    tick();
    reset = 1'b0;
    memReady = 1'b1; rdata = 32'hBAD0BAD0;
    tick();
    memReady = 1'b0; rdata = 32'h0;
    for (int i = 0; i < 2; i++) begin
      checks++;
      if (aMemReady1 !== 1'b0 || bMemReady1 !== 1'b0 || aRdata1 !== 32'h0 || re1 !== 1'b0) begin
        errors++;
        $display("[TB] FAIL stray_ready_%0d: got aRdy=%0b bRdy=%0b aRdata=%h re=%0b expected 0/0/0/0",
                 i, aMemReady1, bMemReady1, aRdata1, re1);
      end
      tick();
    end
    aRe = 1'b1; aAddr = 30'h70;
    tick();
    aRe = 1'b0; aAddr = 30'h0;
    tick();
    checks++;
    if (re1 !== 1'b1 || addr1 !== 30'h70) begin
      errors++;
      $display("[TB] FAIL post_reset_issue: got re=%0b addr=%h expected 1/70", re1, addr1);
    end
    memReady = 1'b1; rdata = 32'h600D600D;
    tick();
    memReady = 1'b0; rdata = 32'h0;
    checks++;
    if (aMemReady1 !== 1'b1 || aRdata1 !== 32'h600D600D) begin
      errors++;
      $display("[TB] FAIL post_reset_resp: got aRdy=%0b aRdata=%h expected 1/600d600d", aMemReady1, aRdata1);
    end
    tick();
  endtask

  initial begin
    test_reset();
    test_single_read();
    test_byte_write();
    test_collision_first();
    test_zero_wait();
    test_collision_second();
    test_wait_states();
    test_reset_mid_wait();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
